// File: rtl/prbs_rx_checker.sv
// prbs_rx_checker
//   Receive-side PRBS-7 (x^7 + x^6 + 1) checker for the decoded bit stream.
//   Hunts for the sequence by loading the shift register from received data,
//   declares lock after LOCK_CNT consecutive correct predictions, then
//   free-runs its own generator and counts mismatches. Too many errors inside
//   one WIN-bit window drop it back to hunting.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   valid_i   bit_i is valid this cycle
//   bit_i     decoded data bit
//   clear_i   synchronous clear of bit_ct_o / err_ct_o (lock state unaffected)
//   locked_o  checker is in LOCKED
//   err_o     one-cycle pulse: last valid bit mismatched while LOCKED
//   bit_ct_o  valid bits checked while LOCKED, saturating
//   err_ct_o  mismatches while LOCKED, saturating
//   lost_o    one-cycle pulse on LOCKED -> HUNT
//
// state  | meaning
// -------+------------------------------------------------------------
// HUNT   | sr loads from received bits; counting consecutive matches
// LOCKED | sr free-runs from its own prediction; errors counted/windowed

module prbs_rx_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int WIN        = 64,
    parameter int UNLOCK_ERR = 4,
    parameter int CW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic          bit_i,
    input  logic          clear_i,
    output logic          locked_o,
    output logic          err_o,
    output logic [CW-1:0] bit_ct_o,
    output logic [CW-1:0] err_ct_o,
    output logic          lost_o
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [CW-1:0] CT_MAX = '1;

    state_t      state;
    logic [6:0]  sr;
    logic [2:0]  fill_ct;
    logic [7:0]  match_ct;
    logic [15:0] win_ct;
    logic [15:0] win_err;

    logic        pred;
    logic        err;
    logic [16:0] win_err_nxt;
    logic [8:0]  match_nxt;

    assign pred        = sr[6] ^ sr[5];
    assign err         = (bit_i != pred);
    assign win_err_nxt = {1'b0, win_err} + {16'd0, err};
    assign match_nxt   = {1'b0, match_ct} + 9'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sr       <= '0;
            fill_ct  <= '0;
            match_ct <= '0;
            win_ct   <= '0;
            win_err  <= '0;
            locked_o <= 1'b0;
            err_o    <= 1'b0;
            lost_o   <= 1'b0;
            bit_ct_o <= '0;
            err_ct_o <= '0;
        end else begin
            err_o  <= 1'b0;
            lost_o <= 1'b0;

            // Clear has priority over any count from a same-cycle valid bit.
            if (clear_i) begin
                bit_ct_o <= '0;
                err_ct_o <= '0;
            end

            if (valid_i) begin
                case (state)
                    HUNT: begin
                        sr <= {sr[5:0], bit_i};
                        if (fill_ct < 3'd7) begin
                            fill_ct <= fill_ct + 3'd1;
                        end else if (!err && (sr != 7'd0)) begin
                            // All-zero register is excluded so a stuck-at-0
                            // line can never satisfy the recurrence.
                            match_ct <= match_nxt[7:0];
                            if (match_nxt == 9'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked_o <= 1'b1;
                                win_ct   <= '0;
                                win_err  <= '0;
                            end
                        end else begin
                            match_ct <= '0;
                        end
                    end

                    LOCKED: begin
                        // Free-running: received errors never enter sr.
                        sr    <= {sr[5:0], pred};
                        err_o <= err;
                        if (!clear_i) begin
                            if (bit_ct_o != CT_MAX)
                                bit_ct_o <= bit_ct_o + CW'(1);
                            if (err && (err_ct_o != CT_MAX))
                                err_ct_o <= err_ct_o + CW'(1);
                        end
                        if (win_err_nxt >= 17'(UNLOCK_ERR)) begin
                            state    <= HUNT;
                            locked_o <= 1'b0;
                            lost_o   <= 1'b1;
                            fill_ct  <= '0;
                            match_ct <= '0;
                            win_ct   <= '0;
                            win_err  <= '0;
                        end else if (win_ct == 16'(WIN - 1)) begin
                            win_ct  <= '0;
                            win_err <= '0;
                        end else begin
                            win_ct  <= win_ct + 16'd1;
                            win_err <= win_err_nxt[15:0];
                        end
                    end

                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_rx_checker.sv
// tb_prbs_rx_checker
//   Scoreboard bench for prbs_rx_checker. The driver applies inputs on the
//   falling edge, steps a reference model and queues the expected outputs;
//   the monitor pops one entry after every rising edge and compares.

module tb_prbs_rx_checker;

    localparam int LOCK_CNT   = 16;
    localparam int WIN        = 64;
    localparam int UNLOCK_ERR = 4;
    localparam int CW         = 16;
    localparam int CT_MAX     = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_i = 1'b0;
    logic          bit_i = 1'b0;
    logic          clear_i = 1'b0;
    logic          locked_o;
    logic          err_o;
    logic [CW-1:0] bit_ct_o;
    logic [CW-1:0] err_ct_o;
    logic          lost_o;

    always #5 clk = ~clk;

    prbs_rx_checker #(
        .LOCK_CNT  (LOCK_CNT),
        .WIN       (WIN),
        .UNLOCK_ERR(UNLOCK_ERR),
        .CW        (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .bit_i   (bit_i),
        .clear_i (clear_i),
        .locked_o(locked_o),
        .err_o   (err_o),
        .bit_ct_o(bit_ct_o),
        .err_ct_o(err_ct_o),
        .lost_o  (lost_o)
    );

    typedef struct {
        bit locked;
        bit err;
        bit lost;
        int bit_ct;
        int err_ct;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_err_pulses = 0;
    int   n_lost_pulses = 0;

    // Reference model: history of the last seven bits the checker trusts
    // (received bits while hunting, self-predicted bits while locked).
    bit m_locked;
    int m_fill, m_match, m_win_bits, m_win_errs, m_bit_ct, m_err_ct;
    bit m_hist[$];

    // Transmit-side PRBS source: seed bits first, then the recurrence.
    bit tx_hist[$];
    int tx_pre;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_fill     = 0;
        m_match    = 0;
        m_win_bits = 0;
        m_win_errs = 0;
        m_bit_ct   = 0;
        m_err_ct   = 0;
        m_hist.delete();
        repeat (7) m_hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr, output exp_t e);
        bit pred, any_one, mis;
        e.err  = 1'b0;
        e.lost = 1'b0;
        if (clr) begin
            m_bit_ct = 0;
            m_err_ct = 0;
        end
        if (v) begin
            // b[n] = b[n-7] ^ b[n-6]
            pred = m_hist[0] ^ m_hist[1];
            if (!m_locked) begin
                any_one = 1'b0;
                foreach (m_hist[k]) any_one |= m_hist[k];
                if (m_fill < 7) begin
                    m_fill++;
                end else if (b == pred && any_one) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked   = 1'b1;
                        m_win_bits = 0;
                        m_win_errs = 0;
                    end
                end else begin
                    m_match = 0;
                end
                m_hist.push_back(b);
            end else begin
                mis   = (b != pred);
                e.err = mis;
                if (!clr) begin
                    if (m_bit_ct < CT_MAX) m_bit_ct++;
                    if (mis && m_err_ct < CT_MAX) m_err_ct++;
                end
                m_win_bits++;
                if (mis) m_win_errs++;
                if (m_win_errs >= UNLOCK_ERR) begin
                    m_locked   = 1'b0;
                    e.lost     = 1'b1;
                    m_fill     = 0;
                    m_match    = 0;
                    m_win_bits = 0;
                    m_win_errs = 0;
                end else if (m_win_bits == WIN) begin
                    m_win_bits = 0;
                    m_win_errs = 0;
                end
                m_hist.push_back(pred);
            end
            void'(m_hist.pop_front());
        end
        e.locked = m_locked;
        e.bit_ct = m_bit_ct;
        e.err_ct = m_err_ct;
    endtask

    task automatic tx_next(output bit b);
        if (tx_pre > 0) begin
            b = 1'b1;
            tx_pre--;
        end else begin
            b = tx_hist[0] ^ tx_hist[1];
            tx_hist.push_back(b);
            void'(tx_hist.pop_front());
        end
    endtask

    task automatic step(input bit r, input bit v, input bit b, input bit clr);
        exp_t e;
        @(negedge clk);
        rst     = r;
        valid_i = v;
        bit_i   = b;
        clear_i = clr;
        if (r) begin
            #1;
            chk("reset_immediate",
                int'(locked_o) + int'(err_o) + int'(lost_o) + int'(bit_ct_o) + int'(err_ct_o), 0);
            model_reset();
            e.locked = 1'b0;
            e.err    = 1'b0;
            e.lost   = 1'b0;
            e.bit_ct = 0;
            e.err_ct = 0;
        end else begin
            model_step(v, b, clr, e);
        end
        exp_q.push_back(e);
    endtask

    task automatic send(input bit v, input bit flip, input bit clr);
        bit b;
        if (v) begin
            tx_next(b);
            b ^= flip;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        step(1'b0, v, b, clr);
    endtask

    // Valid bits sent until locked_o is seen high; 0 if it never rises.
    task automatic acquire(input bit gaps, output int lock_at);
        int  nb;
        bit  v;
        nb      = 0;
        lock_at = 0;
        for (int i = 0; i < 200 && lock_at == 0; i++) begin
            v = gaps ? (i % 2 == 0) : 1'b1;
            send(v, 1'b0, 1'b0);
            if (v) nb++;
            @(posedge clk);
            #1;
            if (locked_o === 1'b1) lock_at = nb;
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (locked_o !== e.locked || err_o !== e.err || lost_o !== e.lost ||
                    int'(bit_ct_o) != e.bit_ct || int'(err_ct_o) != e.err_ct) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t got lk=%0b err=%0b lost=%0b bc=%0d ec=%0d expected lk=%0b err=%0b lost=%0b bc=%0d ec=%0d",
                             $time, locked_o, err_o, lost_o, bit_ct_o, err_ct_o,
                             e.locked, e.err, e.lost, e.bit_ct, e.err_ct);
                end
                if (err_o === 1'b1) n_err_pulses++;
                if (lost_o === 1'b1) n_lost_pulses++;
            end
        end
    end

    initial begin : driver
        int lock_at, ep0, lp0;
        int p[4];
        bit flip;

        tx_pre = 7;
        tx_hist.delete();
        repeat (7) tx_hist.push_back(1'b1);
        model_reset();

        // Reset and idle
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        settle();
        chk("idle_locked", int'(locked_o), 0);
        chk("idle_bit_ct", int'(bit_ct_o), 0);

        // Clean acquisition and 1000 clean bits
        acquire(1'b0, lock_at);
        chk("lock_latency_clean", lock_at, LOCK_CNT + 7);
        ep0 = n_err_pulses;
        for (int i = 0; i < 1000; i++) send(1'b1, 1'b0, 1'b0);
        settle();
        chk("clean_bit_ct", int'(bit_ct_o), 1000);
        chk("clean_err_ct", int'(err_ct_o), 0);
        chk("clean_err_pulses", n_err_pulses - ep0, 0);

        // Single error at bit 500
        ep0 = n_err_pulses;
        for (int j = 1; j <= 500; j++) send(1'b1, j == 500, 1'b0);
        settle();
        chk("single_err_ct", int'(err_ct_o), 1);
        chk("single_bit_ct", int'(bit_ct_o), 1500);
        chk("single_locked", int'(locked_o), 1);
        chk("single_err_pulses", n_err_pulses - ep0, 1);

        // Loss of lock: four errors inside one window
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < WIN && m_win_bits != 0; i++) send(1'b1, 1'b0, 1'b0);
        p[0] = $urandom_range(1, 10);
        for (int k = 1; k < 4; k++) p[k] = p[k-1] + $urandom_range(1, 15);
        lp0 = n_lost_pulses;
        for (int j = 1; j <= p[3]; j++) begin
            flip = (j == p[0]) || (j == p[1]) || (j == p[2]) || (j == p[3]);
            send(1'b1, flip, 1'b0);
        end
        settle();
        chk("loss_lost_pulses", n_lost_pulses - lp0, 1);
        chk("loss_locked", int'(locked_o), 0);
        chk("loss_err_ct", int'(err_ct_o), 4);
        acquire(1'b0, lock_at);
        chk("lock_latency_relock", lock_at, LOCK_CNT + 7);

        // Window boundary: 3 errors at end of one window, 3 at start of next
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * WIN && m_win_bits != WIN - 3; i++) send(1'b1, 1'b0, 1'b0);
        lp0 = n_lost_pulses;
        for (int j = 0; j < 6; j++) send(1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) send(1'b1, 1'b0, 1'b0);
        settle();
        chk("window_locked", int'(locked_o), 1);
        chk("window_err_ct", int'(err_ct_o), 6);
        chk("window_lost_pulses", n_lost_pulses - lp0, 0);

        // Stuck-at-0 line never locks
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("stuck_locked", int'(locked_o), 0);

        // PRBS with valid gaps
        acquire(1'b1, lock_at);
        chk("lock_latency_gaps", lock_at, LOCK_CNT + 7);
        for (int i = 0; i < 40; i++) send(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        settle();
        chk("gaps_locked", int'(locked_o), 1);

        // Reset mid-lock (immediate check inside step), then clear while locked
        step(1'b1, 1'b0, 1'b0, 1'b0);
        acquire(1'b0, lock_at);
        chk("lock_latency_after_rst", lock_at, LOCK_CNT + 7);
        for (int i = 0; i < 30; i++) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        settle();
        chk("clear_bit_ct", int'(bit_ct_o), 0);
        chk("clear_err_ct", int'(err_ct_o), 0);
        chk("clear_locked", int'(locked_o), 1);

        // Randomized traffic: gaps, sparse errors (some windows lose lock), clears
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                step(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                bit v;
                v = ($urandom_range(0, 9) < 7);
                send(v, v && ($urandom_range(0, 99) < 3), $urandom_range(0, 299) == 0);
            end
        end

        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
